saes_mc_engine: RTL
===================

# saes_mc_engine

Multi-channel streaming successor to the 16-bit mini-AES encryptor. It holds per-channel key, chaining value, mode and round count, and accepts plaintext blocks on a valid/ready stream tagged with a channel number. It runs one S-AES round per clock and returns ciphertext on a valid/ready output stream. It sits between a host configuration port and a block-stream source/sink.

## Interface
- CH_LOG2, 2, log2 of channel count; CH = 2**CH_LOG2 contexts
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- cfg_we  in  1  write channel context; honoured only when busy=0
- cfg_chan  in  CH_LOG2  context index
- cfg_key  in  16  channel key K0
- cfg_iv  in  16  initial chaining value (CBC IV / CTR counter)
- cfg_mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 treated as ECB
- cfg_rounds  in  4  round count; 0 is treated as 1
- s_valid / s_ready  in / out  1  input handshake
- s_data  in  16  plaintext block
- s_chan  in  CH_LOG2  channel tag
- m_valid / m_ready  out / in  1  output handshake
- m_data  out  16  ciphertext block
- m_chan  out  CH_LOG2  channel tag of m_data
- busy  out  1  block in flight (RUN state)

## Operation
- Block layout: nibbles n0..n3 = d[15:12], d[11:8], d[7:4], d[3:0]. Column 0 is (n0,n1); column 1 is (n2,n3).
- SubNib: S-box 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7, indexed by the nibble value.
- ShiftRows: swap n1 and n3.
- MixColumns: per column, [1 4; 4 1] over GF(2^4) mod x^4+x+1.
- Key schedule, computed one round per cycle alongside the data:
  - w0 = K[15:8], w1 = K[7:0].
  - w_new0 = w0 ^ {rc_i,4'h0} ^ SubNib(RotNib(w1)).
  - w_new1 = w_new0 ^ w1.
  - rc_1 = 8; rc_{i+1} = rc_i·x in GF(2^4), giving 8,3,6,C,B,5,...
- Encryption of block input B:
  - Pre-whitening: state = B ^ K0.
  - Rounds 1..R-1: SubNib, ShiftRows, MixColumns, add Ki.
  - Round R: SubNib, ShiftRows, add KR (no MixColumns).
- B and m_data per mode, with C = chain[ch]:
  - ECB: B = s_data; m_data = E(B).
  - CBC: B = s_data ^ C; m_data = E(B); chain[ch] ← m_data.
  - CTR: B = C; m_data = s_data ^ E(C); chain[ch] ← C+1 mod 2^16.
  - Chaining update happens in the cycle m_valid rises.
- Accept snapshot: key, mode, rounds, s_data and channel are latched at the accept edge. Later cfg writes never affect a block already in flight.
- FSM:
  - IDLE: s_ready = !m_valid || m_ready. On s_valid&&s_ready, load state with B^K0 and go to RUN with rnd=1.
  - RUN: each cycle apply round rnd and advance the key. When rnd == R, set m_valid and m_data and go to IDLE; otherwise rnd++.
- Output register: m_valid is held until m_ready. m_data and m_chan stay stable while m_valid && !m_ready.
- Config: cfg_we while busy=1 is silently dropped. A cfg write and an s accept in the same cycle on the same channel: the block uses the old context, and the new context applies to the next block.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_chan=0, busy=0, s_ready=1.
  - All contexts: key=0, iv=0, ECB, rounds=2.
- Latency: accept at edge t gives m_valid high after edge t+R. One block is in flight at a time.
- Throughput: one block per R+1 cycles when m_ready is held high. A new accept is allowed in the same cycle the previous output is consumed.
- Reset mid-RUN aborts the block. No output is produced and chaining values return to reset values.
- The counter wraps 16'hFFFF → 16'h0000.

## Configuration
- SAES_CTR_EN:
  - Defined: CTR mode (cfg_mode=10) is built as above.
  - Undefined: the CTR datapath and incrementer are omitted. Mode 10 behaves as ECB and the chaining value is untouched.

## Test plan
- ECB, ch0, key 0xA73B, R=2, s_data 0x6F6B → m_data 0x0738, m_valid two cycles after accept, m_chan=0.
- CBC, ch1, IV 0, same key, two blocks 0x6F6B, 0x6F6B:
  - First → 0x0738.
  - Second → E(0x6853) per the model.
  - chain[1] ends equal to the second output.
- CTR (SAES_CTR_EN), ch2, IV 0x6F6B, key 0xA73B, s_data 0x0000 → 0x0738; chain[2] becomes 0x6F6C. IV 0xFFFF wraps to 0x0000.
- Backpressure: hold m_ready=0 for 5 cycles → m_data stable, s_ready=0; release → accept next block in the same cycle.
- Channel isolation and config: interleave ch0 ECB with ch3 CBC → each matches the model. cfg_we during busy → context unchanged.
- Reset asserted mid-RUN with R=8 → m_valid stays 0, all outputs take reset values, next ECB block correct.

Source files
------------

// File: rtl/saes_mc_engine.sv
`default_nettype none
//==============================================================================
// Module   : saes_mc_engine
// Brief    : multi-channel S-AES encryptor, one round per clock, ECB/CBC/CTR.
//            CTR datapath is built only when SAES_CTR_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
module saes_mc_engine #(
    parameter int CH_LOG2 = 2
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cfg_we,
    input  logic [CH_LOG2-1:0] cfg_chan,
    input  logic [15:0]        cfg_key,
    input  logic [15:0]        cfg_iv,
    input  logic [1:0]         cfg_mode,
    input  logic [3:0]         cfg_rounds,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [15:0]        s_data,
    input  logic [CH_LOG2-1:0] s_chan,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [15:0]        m_data,
    output logic [CH_LOG2-1:0] m_chan,
    output logic               busy
);

    localparam int         c_CH     = 1 << CH_LOG2;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_M_ECB  = 2'b00;
    localparam logic [1:0] c_M_CBC  = 2'b01;
    localparam logic [1:0] c_M_CTR  = 2'b10;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
            4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
            4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
        endcase
        return r;
    endfunction

    // Multiply by x in GF(2^4) modulo x^4+x+1.
    function automatic logic [3:0] gf_x(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] gf_x4(input logic [3:0] a);
        return gf_x(gf_x(a));
    endfunction

    function automatic logic [15:0] key_next(input logic [15:0] k, input logic [3:0] rc);
        logic [7:0] t;
        logic [7:0] n0;
        t  = {sbox(k[3:0]), sbox(k[7:4])};
        n0 = k[15:8] ^ {rc, 4'h0} ^ t;
        return {n0, n0 ^ k[7:0]};
    endfunction

    function automatic logic [15:0] enc_round(input logic [15:0] st, input logic [15:0] rk,
                                              input logic last);
        logic [15:0] s;
        logic [15:0] r;
        s = {sbox(st[15:12]), sbox(st[3:0]), sbox(st[7:4]), sbox(st[11:8])};
        if (last) begin
            r = s;
        end else begin
            r = {s[15:12] ^ gf_x4(s[11:8]), gf_x4(s[15:12]) ^ s[11:8],
                 s[7:4]   ^ gf_x4(s[3:0]),  gf_x4(s[7:4])   ^ s[3:0]};
        end
        return r ^ rk;
    endfunction

    logic [15:0]        r_key_q    [c_CH];
    logic [15:0]        r_chain_q  [c_CH];
    logic [1:0]         r_cmode_q  [c_CH];
    logic [3:0]         r_crnds_q  [c_CH];
    logic [15:0]        w_key_d    [c_CH];
    logic [15:0]        w_chain_d  [c_CH];
    logic [1:0]         w_cmode_d  [c_CH];
    logic [3:0]         w_crnds_d  [c_CH];

    logic [1:0]         r_state_q,   w_state_d;
    logic [3:0]         r_rnd_q,     w_rnd_d;
    logic [3:0]         r_rounds_q,  w_rounds_d;
    logic [1:0]         r_mode_q,    w_mode_d;
    logic [CH_LOG2-1:0] r_chan_q,    w_chan_d;
    logic [15:0]        r_data_q,    w_data_d;
    logic [15:0]        r_rkey_q,    w_rkey_d;
    logic [3:0]         r_rc_q,      w_rc_d;
    logic               r_ctx_new_q, w_ctx_new_d;
    logic               r_m_valid_q, w_m_valid_d;
    logic [15:0]        r_m_data_q,  w_m_data_d;
    logic [CH_LOG2-1:0] r_m_chan_q,  w_m_chan_d;
`ifdef SAES_CTR_EN
    logic [15:0]        r_ctr_q,     w_ctr_d;
    logic [15:0]        r_sdata_q,   w_sdata_d;
`endif

    logic               w_accept;
    logic               w_cfg_ok;
    logic [1:0]         w_acc_mode;
    logic [15:0]        w_ctx_key;
    logic [15:0]        w_ctx_chain;
    logic [3:0]         w_ctx_rnds;
    logic [15:0]        w_blk;
    logic [15:0]        w_rkey_next;
    logic [15:0]        w_round_out;
    logic [15:0]        w_result;

    assign busy    = (r_state_q == c_S_RUN);
    assign s_ready = (r_state_q == c_S_IDLE) && (!r_m_valid_q || m_ready);
    assign m_valid = r_m_valid_q;
    assign m_data  = r_m_data_q;
    assign m_chan  = r_m_chan_q;

    assign w_accept    = s_valid && s_ready;
    assign w_cfg_ok    = cfg_we && !busy;
    assign w_ctx_key   = r_key_q[s_chan];
    assign w_ctx_chain = r_chain_q[s_chan];
    assign w_ctx_rnds  = r_crnds_q[s_chan];
    assign w_rkey_next = key_next(r_rkey_q, r_rc_q);
    assign w_round_out = enc_round(r_data_q, w_rkey_next, r_rnd_q == r_rounds_q);

    // Mode 11 (and 10 when CTR is not built) collapses to ECB at accept time.
    always_comb begin
        w_acc_mode = c_M_ECB;
        w_blk      = s_data;
        case (r_cmode_q[s_chan])
            c_M_CBC: begin
                w_acc_mode = c_M_CBC;
                w_blk      = s_data ^ w_ctx_chain;
            end
`ifdef SAES_CTR_EN
            c_M_CTR: begin
                w_acc_mode = c_M_CTR;
                w_blk      = w_ctx_chain;
            end
`endif
            default: begin
                w_acc_mode = c_M_ECB;
                w_blk      = s_data;
            end
        endcase
    end

`ifdef SAES_CTR_EN
    assign w_result = (r_mode_q == c_M_CTR) ? (r_sdata_q ^ w_round_out) : w_round_out;
`else
    assign w_result = w_round_out;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_rnd_d     = r_rnd_q;
        w_rounds_d  = r_rounds_q;
        w_mode_d    = r_mode_q;
        w_chan_d    = r_chan_q;
        w_data_d    = r_data_q;
        w_rkey_d    = r_rkey_q;
        w_rc_d      = r_rc_q;
        w_ctx_new_d = r_ctx_new_q;
        w_m_valid_d = r_m_valid_q;
        w_m_data_d  = r_m_data_q;
        w_m_chan_d  = r_m_chan_q;
`ifdef SAES_CTR_EN
        w_ctr_d     = r_ctr_q;
        w_sdata_d   = r_sdata_q;
`endif
        for (int i = 0; i < c_CH; i++) begin
            w_key_d[i]   = r_key_q[i];
            w_chain_d[i] = r_chain_q[i];
            w_cmode_d[i] = r_cmode_q[i];
            w_crnds_d[i] = r_crnds_q[i];
        end

        if (r_m_valid_q && m_ready) begin
            w_m_valid_d = 1'b0;
        end

        if (w_cfg_ok) begin
            w_key_d[cfg_chan]   = cfg_key;
            w_chain_d[cfg_chan] = cfg_iv;
            w_cmode_d[cfg_chan] = cfg_mode;
            w_crnds_d[cfg_chan] = cfg_rounds;
        end

        case (r_state_q)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_d   = c_S_RUN;
                    w_rnd_d     = 4'd1;
                    w_rounds_d  = (w_ctx_rnds == 4'd0) ? 4'd1 : w_ctx_rnds;
                    w_mode_d    = w_acc_mode;
                    w_chan_d    = s_chan;
                    w_rkey_d    = w_ctx_key;
                    w_rc_d      = 4'h8;
                    w_data_d    = w_blk ^ w_ctx_key;
                    // A same-cycle cfg write owns the chain value from now on.
                    w_ctx_new_d = w_cfg_ok && (cfg_chan == s_chan);
`ifdef SAES_CTR_EN
                    w_ctr_d     = w_ctx_chain;
                    w_sdata_d   = s_data;
`endif
                end
            end
            c_S_RUN: begin
                w_rkey_d = w_rkey_next;
                w_rc_d   = gf_x(r_rc_q);
                w_data_d = w_round_out;
                if (r_rnd_q == r_rounds_q) begin
                    w_state_d   = c_S_IDLE;
                    w_m_valid_d = 1'b1;
                    w_m_data_d  = w_result;
                    w_m_chan_d  = r_chan_q;
                    if (!r_ctx_new_q) begin
                        if (r_mode_q == c_M_CBC) begin
                            w_chain_d[r_chan_q] = w_round_out;
                        end
`ifdef SAES_CTR_EN
                        if (r_mode_q == c_M_CTR) begin
                            w_chain_d[r_chan_q] = r_ctr_q + 16'd1;
                        end
`endif
                    end
                end else begin
                    w_rnd_d = r_rnd_q + 4'd1;
                end
            end
            default: begin
                w_state_d = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state_q   <= c_S_IDLE;
            r_rnd_q     <= 4'd0;
            r_rounds_q  <= 4'd0;
            r_mode_q    <= c_M_ECB;
            r_chan_q    <= '0;
            r_data_q    <= 16'h0000;
            r_rkey_q    <= 16'h0000;
            r_rc_q      <= 4'h0;
            r_ctx_new_q <= 1'b0;
            r_m_valid_q <= 1'b0;
            r_m_data_q  <= 16'h0000;
            r_m_chan_q  <= '0;
`ifdef SAES_CTR_EN
            r_ctr_q     <= 16'h0000;
            r_sdata_q   <= 16'h0000;
`endif
            for (int i = 0; i < c_CH; i++) begin
                r_key_q[i]   <= 16'h0000;
                r_chain_q[i] <= 16'h0000;
                r_cmode_q[i] <= c_M_ECB;
                r_crnds_q[i] <= 4'd2;
            end
        end else begin
            r_state_q   <= w_state_d;
            r_rnd_q     <= w_rnd_d;
            r_rounds_q  <= w_rounds_d;
            r_mode_q    <= w_mode_d;
            r_chan_q    <= w_chan_d;
            r_data_q    <= w_data_d;
            r_rkey_q    <= w_rkey_d;
            r_rc_q      <= w_rc_d;
            r_ctx_new_q <= w_ctx_new_d;
            r_m_valid_q <= w_m_valid_d;
            r_m_data_q  <= w_m_data_d;
            r_m_chan_q  <= w_m_chan_d;
`ifdef SAES_CTR_EN
            r_ctr_q     <= w_ctr_d;
            r_sdata_q   <= w_sdata_d;
`endif
            for (int i = 0; i < c_CH; i++) begin
                r_key_q[i]   <= w_key_d[i];
                r_chain_q[i] <= w_chain_d[i];
                r_cmode_q[i] <= w_cmode_d[i];
                r_crnds_q[i] <= w_crnds_d[i];
            end
        end
    end

endmodule
`default_nettype wire
